// File: rtl/pilot_avg_n.sv
// Pilot averager: accumulates 2**LOG2_NP complex pilots per symbol and emits the rounded,
// saturated mean, with optional exponential smoothing across symbols and conjugated output.
module pilot_avg_n #(
  parameter int unsigned Q        = 16,
  parameter int unsigned Q_DEC    = 9,
  parameter int unsigned LOG2_NP  = 2,
  parameter int unsigned ROUND    = 1,
  parameter int unsigned CONJ     = 1,
  parameter int unsigned ALPHA_SH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sym_start,
  input  logic                  hist_clr,
  input  logic                  smooth_en,
  input  logic                  pilot_valid,
  input  logic signed [Q-1:0]   pilot_r,
  input  logic signed [Q-1:0]   pilot_i,
  output logic                  avg_valid,
  output logic signed [Q-1:0]   avg_r,
  output logic signed [Q-1:0]   avg_i,
  output logic [LOG2_NP-1:0]    pilot_cnt
);

  localparam int unsigned NP = 2 ** LOG2_NP;
  localparam int unsigned AW = Q + LOG2_NP;
  // One guard bit above the accumulator covers the rounding constant and all Q-wide arithmetic.
  localparam int unsigned W  = AW + 1;

  localparam logic [LOG2_NP-1:0] LastCnt = LOG2_NP'(NP - 1);
  localparam logic signed [W-1:0] RndK   = (ROUND != 0) ? W'(NP / 2) : '0;
  localparam logic signed [W-1:0] SatMax = W'((2 ** (Q - 1)) - 1);
  localparam logic signed [W-1:0] SatMin = ~SatMax;
  localparam logic signed [Q-1:0] MaxQ   = {1'b0, {(Q - 1){1'b1}}};
  localparam logic signed [Q-1:0] MinQ   = {1'b1, {(Q - 1){1'b0}}};

  if (Q_DEC >= Q || LOG2_NP < 1 || ALPHA_SH < 1) begin : g_param_check
    $error("pilot_avg_n: illegal parameter combination");
  end

  function automatic logic signed [W-1:0] sx(input logic signed [Q-1:0] v);
    return W'(v);
  endfunction

  function automatic logic signed [Q-1:0] sat_w(input logic signed [W-1:0] x);
    if (x > SatMax) return MaxQ;
    if (x < SatMin) return MinQ;
    return x[Q-1:0];
  endfunction

  function automatic logic signed [Q-1:0] blk_of(input logic signed [AW-1:0] s);
    logic signed [W-1:0] t;
    t = W'(s) + RndK;
    t = t >>> LOG2_NP;
    return sat_w(t);
  endfunction

  function automatic logic signed [Q-1:0] smooth(input logic signed [Q-1:0] b,
                                                  input logic signed [Q-1:0] p);
    logic signed [W-1:0] d;
    d = sx(b) - sx(p);
    d = d >>> ALPHA_SH;
    return sat_w(sx(p) + d);
  endfunction

  logic signed [AW-1:0]   acc_r_q, acc_r_d, acc_i_q, acc_i_d;
  logic [LOG2_NP-1:0]     pilot_cnt_q, pilot_cnt_d;
  logic                   hist_valid_q, hist_valid_d;
  logic signed [Q-1:0]    prev_r_q, prev_r_d, prev_i_q, prev_i_d;
  logic signed [Q-1:0]    avg_r_q, avg_r_d, avg_i_q, avg_i_d;
  logic                   avg_valid_q, avg_valid_d;

  logic [LOG2_NP-1:0]     cnt_eff;
  logic signed [AW-1:0]   sum_r, sum_i;
  logic signed [Q-1:0]    blk_r, blk_i, est_r, est_i;
  logic                   done, use_hist;

  always_comb begin
    cnt_eff  = sym_start ? '0 : pilot_cnt_q;
    sum_r    = (cnt_eff == '0) ? AW'(pilot_r) : acc_r_q + AW'(pilot_r);
    sum_i    = (cnt_eff == '0) ? AW'(pilot_i) : acc_i_q + AW'(pilot_i);
    done     = pilot_valid && (cnt_eff == LastCnt);
    blk_r    = blk_of(sum_r);
    blk_i    = blk_of(sum_i);
    // A history clear on the completing edge forces an unsmoothed estimate.
    use_hist = smooth_en && hist_valid_q && !hist_clr;
    est_r    = use_hist ? smooth(blk_r, prev_r_q) : blk_r;
    est_i    = use_hist ? smooth(blk_i, prev_i_q) : blk_i;

    acc_r_d      = acc_r_q;
    acc_i_d      = acc_i_q;
    pilot_cnt_d  = pilot_cnt_q;
    hist_valid_d = hist_valid_q;
    prev_r_d     = prev_r_q;
    prev_i_d     = prev_i_q;
    avg_r_d      = avg_r_q;
    avg_i_d      = avg_i_q;
    avg_valid_d  = 1'b0;

    if (pilot_valid) begin
      acc_r_d     = sum_r;
      acc_i_d     = sum_i;
      pilot_cnt_d = cnt_eff + 1'b1;
    end else if (sym_start) begin
      pilot_cnt_d = '0;
    end

    if (hist_clr) hist_valid_d = 1'b0;

    if (done) begin
      prev_r_d     = est_r;
      prev_i_d     = est_i;
      hist_valid_d = 1'b1;
      avg_r_d      = est_r;
      avg_i_d      = (CONJ != 0) ? sat_w(-sx(est_i)) : est_i;
      avg_valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r_q      <= '0;
      acc_i_q      <= '0;
      pilot_cnt_q  <= '0;
      hist_valid_q <= 1'b0;
      prev_r_q     <= '0;
      prev_i_q     <= '0;
      avg_r_q      <= '0;
      avg_i_q      <= '0;
      avg_valid_q  <= 1'b0;
    end else begin
      acc_r_q      <= acc_r_d;
      acc_i_q      <= acc_i_d;
      pilot_cnt_q  <= pilot_cnt_d;
      hist_valid_q <= hist_valid_d;
      prev_r_q     <= prev_r_d;
      prev_i_q     <= prev_i_d;
      avg_r_q      <= avg_r_d;
      avg_i_q      <= avg_i_d;
      avg_valid_q  <= avg_valid_d;
    end
  end

  assign avg_valid = avg_valid_q;
  assign avg_r     = avg_r_q;
  assign avg_i     = avg_i_q;
  assign pilot_cnt = pilot_cnt_q;

endmodule

// File: tb/tb_pilot_avg_n.sv
// Directed bench for pilot_avg_n: default instance plus a truncating, non-conjugating twin.
module tb_pilot_avg_n;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sym_start = 1'b0, hist_clr = 1'b0, smooth_en = 1'b0, pilot_valid = 1'b0;
  logic signed [15:0] pilot_r = '0, pilot_i = '0;

  logic avg_valid, avg_valid_t;
  logic signed [15:0] avg_r, avg_i, avg_r_t, avg_i_t;
  logic [1:0] pilot_cnt, pilot_cnt_t;

  int n_tests = 0;
  int n_fail  = 0;
  int pulses  = 0;

  always #5 clk = ~clk;

  pilot_avg_n u_dut (
    .clk(clk), .rst_n(rst_n), .sym_start(sym_start), .hist_clr(hist_clr),
    .smooth_en(smooth_en), .pilot_valid(pilot_valid), .pilot_r(pilot_r), .pilot_i(pilot_i),
    .avg_valid(avg_valid), .avg_r(avg_r), .avg_i(avg_i), .pilot_cnt(pilot_cnt)
  );

  pilot_avg_n #(.ROUND(0), .CONJ(0)) u_dut_t (
    .clk(clk), .rst_n(rst_n), .sym_start(sym_start), .hist_clr(hist_clr),
    .smooth_en(smooth_en), .pilot_valid(pilot_valid), .pilot_r(pilot_r), .pilot_i(pilot_i),
    .avg_valid(avg_valid_t), .avg_r(avg_r_t), .avg_i(avg_i_t), .pilot_cnt(pilot_cnt_t)
  );

  always @(posedge clk) if (avg_valid) pulses <= pulses + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Present one pilot for one edge, then drop valid/sym_start.
  task automatic pil(input int r, input int i, input bit ss);
    pilot_valid = 1'b1;
    pilot_r     = 16'(r);
    pilot_i     = 16'(i);
    sym_start   = ss;
    tick();
    pilot_valid = 1'b0;
    sym_start   = 1'b0;
  endtask

  task automatic block4(input int r, input int i);
    for (int k = 0; k < 4; k++) pil(r, i, 1'b0);
  endtask

  task automatic idle();
    tick();
  endtask

  initial begin
    int p0;
    tick();
    check("reset_avg_valid", int'(avg_valid), 0);
    check("reset_avg_r", int'(avg_r), 0);
    check("reset_pilot_cnt", int'(pilot_cnt), 0);
    rst_n = 1'b1;
    idle();

    // T1: basic mean and conjugation, pulse one cycle after the 4th pilot
    p0 = pulses;
    pil(100, -40, 0); pil(200, -40, 0); pil(300, -40, 0);
    check("t1_no_early_pulse", int'(avg_valid), 0);
    pil(400, -40, 0);
    check("t1_avg_valid", int'(avg_valid), 1);
    check("t1_avg_r", int'(avg_r), 250);
    check("t1_avg_i", int'(avg_i), 40);
    check("t1_twin_avg_i", int'(avg_i_t), -40);
    idle();
    check("t1_pulse_drop", int'(avg_valid), 0);
    check("t1_hold_avg_r", int'(avg_r), 250);
    check("t1_pulse_count", pulses - p0, 1);

    // T2: rounding vs truncation
    pil(1, 0, 0); pil(2, 0, 0); pil(2, 0, 0); pil(2, 0, 0);
    check("t2_round_pos", int'(avg_r), 2);
    check("t2_trunc_pos", int'(avg_r_t), 1);
    pil(-1, 0, 0); pil(-2, 0, 0); pil(-2, 0, 0); pil(-2, 0, 0);
    check("t2_round_neg", int'(avg_r), -2);
    check("t2_trunc_neg", int'(avg_r_t), -2);
    idle();

    // T3: saturation at both extremes, back-to-back with previous traffic
    block4(32767, -32768);
    check("t3_sat_r", int'(avg_r), 32767);
    check("t3_conj_sat_i", int'(avg_i), 32767);
    check("t3_twin_i", int'(avg_i_t), -32768);
    idle();

    // T4: sym_start restarts the symbol
    p0 = pulses;
    pil(1000, 0, 0);
    check("t4_cnt1", int'(pilot_cnt), 1);
    pil(1000, 0, 0);
    check("t4_cnt2", int'(pilot_cnt), 2);
    pil(8, 0, 1);
    check("t4_cnt_restart", int'(pilot_cnt), 1);
    pil(8, 0, 0);
    check("t4_cnt2b", int'(pilot_cnt), 2);
    pil(8, 0, 0);
    check("t4_cnt3", int'(pilot_cnt), 3);
    pil(8, 0, 0);
    check("t4_cnt0", int'(pilot_cnt), 0);
    check("t4_avg_r", int'(avg_r), 8);
    idle();
    check("t4_pulse_count", pulses - p0, 1);
    // sym_start without valid discards a partial symbol
    pil(500, 0, 0); pil(500, 0, 0);
    sym_start = 1'b1; tick(); sym_start = 1'b0;
    check("t4_ss_idle_cnt", int'(pilot_cnt), 0);

    // T5: smoothing with alpha = 1/4
    hist_clr = 1'b1; tick(); hist_clr = 1'b0;
    smooth_en = 1'b1;
    block4(400, 0);
    check("t5_first", int'(avg_r), 400);
    block4(0, 0);
    check("t5_second", int'(avg_r), 300);
    block4(0, 0);
    check("t5_third", int'(avg_r), 225);
    hist_clr = 1'b1; tick(); hist_clr = 1'b0;
    block4(0, 0);
    check("t5_after_clr", int'(avg_r), 0);
    // hist_clr on the completing edge still yields the raw block mean
    block4(400, 0);
    check("t5_smooth_up", int'(avg_r), 100);
    pil(0, 0, 0); pil(0, 0, 0); pil(0, 0, 0);
    hist_clr = 1'b1;
    pil(0, 0, 0);
    hist_clr = 1'b0;
    check("t5_clr_on_done", int'(avg_r), 0);

    // T6: asynchronous reset mid-symbol
    smooth_en = 1'b0;
    block4(100, -20);
    check("t6_pre_avg_r", int'(avg_r), 100);
    smooth_en = 1'b1;
    pil(7, 7, 0); pil(7, 7, 0); pil(7, 7, 0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_avg_r", int'(avg_r), 0);
    check("t6_rst_avg_i", int'(avg_i), 0);
    check("t6_rst_cnt", int'(pilot_cnt), 0);
    check("t6_rst_valid", int'(avg_valid), 0);
    tick();
    rst_n = 1'b1;
    idle();
    block4(12, 0);
    check("t6_after_rst", int'(avg_r), 12);
    check("t6_valid", int'(avg_valid), 1);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
